dmem_burst_copy_engine: RTL and testbench
=========================================

# dmem_burst_copy_engine

Initiator-side DMA engine for the IO↔DMem burst protocol (separate read/write address, data and status channels with valid/ready handshakes). Given a source address, destination address and word count, it issues read bursts, buffers the returned words in an internal FIFO, then writes them back as write bursts, chunk by chunk, until the copy is complete or a write fails. It sits between an IO accelerator's control registers and the DMem-side IO controller.

## Interface
- AWIDTH, 32: address width (word addresses).
- DWIDTH, 32: data width.
- CHUNK, 16: max words per burst; also the FIFO depth. Power of two, ≥2.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle copy request; honoured only when busy=0.
- src_addr  in  AWIDTH  source word address, captured on accepted start.
- dst_addr  in  AWIDTH  destination word address, captured on accepted start.
- len  in  32  words to copy, captured on accepted start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of copy.
- error  out  1  sticky; set when a write status returns 0, cleared on next accepted start.
- req_read_addr / _valid / _ready, req_read_len  out/out/in/out  AWIDTH/1/1/32  read address channel.
- resp_read_data / _valid / _ready  in/in/out  DWIDTH/1/1  read data channel.
- req_write_addr / _valid / _ready, req_write_len  out/out/in/out  AWIDTH/1/1/32  write address channel.
- req_write_data / _valid / _ready  out/out/in  DWIDTH/1/1  write data channel.
- resp_write_status / _valid / _ready  in/in/out  1/1/1  write status channel (1 = success).

## Operation
- Fire on any channel = valid & ready in the same cycle.
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_RESP, DONE.
- IDLE: start → latch src, dst, remaining=len, clear error; go RD_REQ if len≠0, else DONE.
- chunk = min(remaining, CHUNK), registered on entry to RD_REQ.
- RD_REQ: req_read_addr_valid=1, addr=src_cur, req_read_len=chunk; on fire → RD_DATA.
- RD_DATA: resp_read_data_ready=1; each fire pushes data into FIFO, beat counter +1; after chunk-th beat → WR_REQ.
- WR_REQ: req_write_addr_valid=1, addr=dst_cur, req_write_len=chunk; on fire → WR_DATA.
- WR_DATA: req_write_data_valid = FIFO non-empty; req_write_data = FIFO head (combinational); each fire pops; after chunk-th beat → WR_RESP.
- WR_RESP: resp_write_status_ready=1; on fire: status 0 → error=1, DONE; status 1 → src_cur+=chunk, dst_cur+=chunk, remaining-=chunk; remaining=0 → DONE else RD_REQ.
- DONE: done=1 for one cycle → IDLE.
- Address arithmetic modulo 2^AWIDTH (wrap, no error). Counters 32-bit.
- Data order preserved exactly; FIFO never overflows (chunk ≤ depth), extra read beats not accepted (ready low outside RD_DATA).
- start while busy ignored; captured operands unchanged.

## Timing
- Reset (async assert, sync deassert assumed from system): state IDLE; busy, done, error, all valid/ready outputs 0; addresses/lens 0; FIFO empty.
- Reset mid-copy aborts immediately with no completion pulse; the responder is reset alongside.
- All handshake outputs are driven from registered state (no comb path from an input ready/valid to an output valid/ready, except req_write_data_valid from FIFO occupancy).
- Valid held with stable payload until fire.
- start accepted at edge N → busy=1 and req_read_addr_valid=1 from N+1.
- len=0: done pulses at N+1, busy never asserts, no channel activity.
- RD_DATA accepts one beat per cycle; WR_DATA issues one beat per cycle while ready is high; a FIFO push/pop never occur in the same state.
- Chunk-to-chunk overhead: 1 cycle each for RD_REQ/WR_REQ/WR_RESP minimum, plus responder latency.
- done and busy=0 coincide in the DONE cycle; new start accepted the following IDLE cycle.

## Test plan
- src=0x100, dst=0x200, len=5, responder latency 10 → one read burst len 5, one write burst len 5 to 0x200..0x204 matching source; done once, error=0.
- len=40, CHUNK=16 → bursts of 16,16,8 at src+0/+16/+32 and dst+0/+16/+32; data intact.
- len=0 → done at N+1, no valid asserted on any channel.
- resp_read_data_valid gapped randomly, req_write_data_ready toggled every other cycle → data order preserved, no lost/duplicated words.
- Second chunk write status=0 with len=32 → error=1, done pulses, no third read request; next start clears error.
- rst_n low during WR_DATA → all outputs 0 asynchronously; after release a new len=3 copy completes correctly.

Source files
------------

// File: rtl/dmem_burst_copy_engine.sv
// rtl/dmem_burst_copy_engine.sv - chunked read-then-write burst DMA engine with internal FIFO
module dmem_burst_copy_engine #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int CHUNK  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] src_addr,
  input  logic [AWIDTH-1:0] dst_addr,
  input  logic [31:0]       len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [AWIDTH-1:0] req_read_addr,
  output logic              req_read_addr_valid,
  input  logic              req_read_addr_ready,
  output logic [31:0]       req_read_len,
  input  logic [DWIDTH-1:0] resp_read_data,
  input  logic              resp_read_data_valid,
  output logic              resp_read_data_ready,
  output logic [AWIDTH-1:0] req_write_addr,
  output logic              req_write_addr_valid,
  input  logic              req_write_addr_ready,
  output logic [31:0]       req_write_len,
  output logic [DWIDTH-1:0] req_write_data,
  output logic              req_write_data_valid,
  input  logic              req_write_data_ready,
  input  logic              resp_write_status,
  input  logic              resp_write_status_valid,
  output logic              resp_write_status_ready
);
  localparam int PW = $clog2(CHUNK);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_RESP, DONE} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] src_q, dst_q;
  logic [31:0]       rem_q, chunk_q, beat_q;
  logic              error_q;
  logic [DWIDTH-1:0] fifo_mem [CHUNK];
  logic [PW:0]       wptr_q, rptr_q;

  logic        rd_addr_fire, rd_data_fire, wr_addr_fire, wr_data_fire, status_fire;
  logic        last_beat, fifo_empty;
  logic [31:0] rem_after;

  function automatic logic [31:0] chunk_of(input logic [31:0] n);
    return (n > 32'(CHUNK)) ? 32'(CHUNK) : n;
  endfunction

  assign rd_addr_fire = req_read_addr_valid & req_read_addr_ready;
  assign rd_data_fire = resp_read_data_valid & resp_read_data_ready;
  assign wr_addr_fire = req_write_addr_valid & req_write_addr_ready;
  assign wr_data_fire = req_write_data_valid & req_write_data_ready;
  assign status_fire  = resp_write_status_valid & resp_write_status_ready;
  assign last_beat    = (beat_q == chunk_q - 32'd1);
  assign fifo_empty   = (wptr_q == rptr_q);
  assign rem_after    = rem_q - chunk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == 32'd0) ? DONE : RD_REQ;
      RD_REQ:  if (rd_addr_fire) state_d = RD_DATA;
      RD_DATA: if (rd_data_fire && last_beat) state_d = WR_REQ;
      WR_REQ:  if (wr_addr_fire) state_d = WR_DATA;
      WR_DATA: if (wr_data_fire && last_beat) state_d = WR_RESP;
      WR_RESP: if (status_fire)
                 state_d = (!resp_write_status || rem_after == 32'd0) ? DONE : RD_REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The beat counter is shared by RD_DATA and WR_DATA; it returns to 0 on each chunk boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      chunk_q <= '0;
      beat_q  <= '0;
      error_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          src_q   <= src_addr;
          dst_q   <= dst_addr;
          rem_q   <= len;
          chunk_q <= chunk_of(len);
          beat_q  <= '0;
          error_q <= 1'b0;
        end
        RD_DATA: if (rd_data_fire) begin
          wptr_q <= wptr_q + 1'b1;
          beat_q <= last_beat ? 32'd0 : beat_q + 32'd1;
        end
        WR_DATA: if (wr_data_fire) begin
          rptr_q <= rptr_q + 1'b1;
          beat_q <= last_beat ? 32'd0 : beat_q + 32'd1;
        end
        WR_RESP: if (status_fire) begin
          if (!resp_write_status) begin
            error_q <= 1'b1;
          end else begin
            src_q   <= src_q + AWIDTH'(chunk_q);
            dst_q   <= dst_q + AWIDTH'(chunk_q);
            rem_q   <= rem_after;
            chunk_q <= chunk_of(rem_after);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rd_data_fire) fifo_mem[wptr_q[PW-1:0]] <= resp_read_data;
  end

  always_comb begin
    busy                    = (state_q != IDLE) && (state_q != DONE);
    done                    = (state_q == DONE);
    error                   = error_q;
    req_read_addr_valid     = (state_q == RD_REQ);
    req_read_addr           = req_read_addr_valid ? src_q : '0;
    req_read_len            = req_read_addr_valid ? chunk_q : '0;
    resp_read_data_ready    = (state_q == RD_DATA);
    req_write_addr_valid    = (state_q == WR_REQ);
    req_write_addr          = req_write_addr_valid ? dst_q : '0;
    req_write_len           = req_write_addr_valid ? chunk_q : '0;
    req_write_data_valid    = (state_q == WR_DATA) && !fifo_empty;
    req_write_data          = req_write_data_valid ? fifo_mem[rptr_q[PW-1:0]] : '0;
    resp_write_status_ready = (state_q == WR_RESP);
  end
endmodule

// File: tb/tb_dmem_burst_copy_engine.sv
// tb/tb_dmem_burst_copy_engine.sv - table-driven and randomized copies against a responder and reference model
module tb_dmem_burst_copy_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [31:0] src_addr, dst_addr, len;
  logic        busy, done, error;
  logic [31:0] req_read_addr, req_read_len, resp_read_data;
  logic        req_read_addr_valid, req_read_addr_ready, resp_read_data_valid, resp_read_data_ready;
  logic [31:0] req_write_addr, req_write_len, req_write_data;
  logic        req_write_addr_valid, req_write_addr_ready, req_write_data_valid, req_write_data_ready;
  logic        resp_write_status, resp_write_status_valid, resp_write_status_ready;

  dmem_burst_copy_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .error(error),
    .req_read_addr(req_read_addr), .req_read_addr_valid(req_read_addr_valid),
    .req_read_addr_ready(req_read_addr_ready), .req_read_len(req_read_len),
    .resp_read_data(resp_read_data), .resp_read_data_valid(resp_read_data_valid),
    .resp_read_data_ready(resp_read_data_ready),
    .req_write_addr(req_write_addr), .req_write_addr_valid(req_write_addr_valid),
    .req_write_addr_ready(req_write_addr_ready), .req_write_len(req_write_len),
    .req_write_data(req_write_data), .req_write_data_valid(req_write_data_valid),
    .req_write_data_ready(req_write_data_ready),
    .resp_write_status(resp_write_status), .resp_write_status_valid(resp_write_status_valid),
    .resp_write_status_ready(resp_write_status_ready)
  );

  typedef struct { logic [31:0] a; logic [31:0] b; } pair_t;
  typedef struct {
    logic [31:0] src, dst, len;
    int lat, gap, wmode, fail, exp_nrd;
    logic exp_err;
  } vec_t;

  int    n_cmp = 0, n_bad = 0;
  int    cfg_lat = 0, cfg_gap = 0, cfg_wmode = 0, cfg_fail = 99;
  pair_t rd_q[$], rd_log[$], wr_log[$], got[$];
  pair_t exp_rd[$], exp_wr[$], exp_w[$];
  pair_t wr_cur;
  int    rd_beat = 0, rd_wait = 0, wr_beat = 0, st_wait = 0, wr_idx = 0, done_cnt = 0;
  bit    rd_fired = 0, st_fired = 0, st_pending = 0, any_valid = 0, any_busy = 0;
  logic  prev_err = 1'b0;

  function automatic logic [31:0] src_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Responder: acts at the negedge, so each valid&ready seen here is the handshake of the next posedge.
  initial begin
    req_read_addr_ready = 0; resp_read_data_valid = 0; resp_read_data = 0;
    req_write_addr_ready = 0; req_write_data_ready = 0;
    resp_write_status = 0; resp_write_status_valid = 0;
    wr_cur = '{32'd0, 32'd0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_read_addr_ready = 0; resp_read_data_valid = 0; req_write_addr_ready = 0;
        req_write_data_ready = 0; resp_write_status_valid = 0;
        rd_q.delete(); rd_fired = 0; st_fired = 0; st_pending = 0;
        rd_beat = 0; rd_wait = 0; wr_beat = 0; st_wait = 0;
      end else begin
        if (done) done_cnt++;
        if (busy) any_busy = 1;
        if (req_read_addr_valid | req_write_addr_valid | req_write_data_valid |
            resp_read_data_ready | resp_write_status_ready) any_valid = 1;

        if (rd_fired) resp_read_data_valid = 0;
        rd_fired = 0;
        if (rd_wait > 0) rd_wait--;
        if (!resp_read_data_valid && rd_q.size() > 0 && rd_wait == 0 &&
            $urandom_range(99, 0) >= cfg_gap) begin
          resp_read_data_valid = 1;
          resp_read_data = src_fn(rd_q[0].a + 32'(rd_beat));
        end
        if (resp_read_data_valid && resp_read_data_ready) begin
          rd_fired = 1;
          rd_beat++;
          if (32'(rd_beat) == rd_q[0].b) begin
            void'(rd_q.pop_front());
            rd_beat = 0;
          end
        end

        req_read_addr_ready = ($urandom_range(99, 0) >= cfg_gap);
        if (req_read_addr_valid && req_read_addr_ready) begin
          rd_log.push_back('{req_read_addr, req_read_len});
          rd_q.push_back('{req_read_addr, req_read_len});
          rd_wait = cfg_lat;
        end

        if (st_fired) begin resp_write_status_valid = 0; st_fired = 0; end
        if (st_pending && !resp_write_status_valid) begin
          if (st_wait > 0) st_wait--;
          else begin
            resp_write_status_valid = 1;
            resp_write_status = (wr_idx != cfg_fail);
          end
        end
        if (resp_write_status_valid && resp_write_status_ready) begin
          st_fired = 1; st_pending = 0; wr_idx++;
        end

        req_write_addr_ready = ($urandom_range(99, 0) >= cfg_gap);
        if (req_write_addr_valid && req_write_addr_ready) begin
          wr_log.push_back('{req_write_addr, req_write_len});
          wr_cur = '{req_write_addr, req_write_len};
          wr_beat = 0;
        end

        case (cfg_wmode)
          0:       req_write_data_ready = 1;
          1:       req_write_data_ready = !req_write_data_ready;
          default: req_write_data_ready = ($urandom_range(1, 0) == 1);
        endcase
        if (req_write_data_valid && req_write_data_ready) begin
          got.push_back('{wr_cur.a + 32'(wr_beat), req_write_data});
          wr_beat++;
          if (32'(wr_beat) == wr_cur.b) begin st_pending = 1; st_wait = cfg_lat / 2; end
        end
      end
    end
  end

  // Reference: walk the copy chunk by chunk; a failed status ends it after that chunk's writes.
  function automatic void build_expect(input vec_t v, output int nrd, output logic err);
    logic [31:0] rem, off, k;
    int idx;
    exp_rd.delete(); exp_wr.delete(); exp_w.delete();
    rem = v.len; off = 0; idx = 0; nrd = 0; err = 0;
    while (rem != 0) begin
      k = (rem > 32'd16) ? 32'd16 : rem;
      exp_rd.push_back('{v.src + off, k});
      exp_wr.push_back('{v.dst + off, k});
      for (int j = 0; j < int'(k); j++)
        exp_w.push_back('{v.dst + off + 32'(j), src_fn(v.src + off + 32'(j))});
      nrd++;
      if (idx == v.fail) begin err = 1; break; end
      rem -= k; off += k; idx++;
    end
  endfunction

  task automatic clear_logs();
    rd_log.delete(); wr_log.delete(); got.delete();
    wr_idx = 0; done_cnt = 0; any_valid = 0; any_busy = 0;
  endtask

  task automatic run_copy(input vec_t v, input string tag);
    int nrd, cyc, n;
    logic err;
    build_expect(v, nrd, err);
    if (v.exp_nrd < 0) begin v.exp_nrd = nrd; v.exp_err = err; end
    chk({tag, " err_sticky"}, error, prev_err);
    cfg_lat = v.lat; cfg_gap = v.gap; cfg_wmode = v.wmode; cfg_fail = v.fail;
    clear_logs();
    @(negedge clk);
    start = 1; src_addr = v.src; dst_addr = v.dst; len = v.len;
    @(negedge clk);
    start = 0; src_addr = 32'hDEAD_BEEF; dst_addr = 32'hCAFE_0000; len = 32'd7;
    chk({tag, " busy_n1"}, busy, v.len != 0);
    chk({tag, " done_n1"}, done, v.len == 0);
    chk({tag, " err_clr"}, error, 0);
    if (v.len != 0) begin
      @(negedge clk); start = 1; src_addr = 32'h5555_0000; dst_addr = 32'h6666_0000; len = 32'd3;
      @(negedge clk); start = 0;
    end
    cyc = 0;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    chk({tag, " timeout"}, cyc < 3000, 1);
    chk({tag, " busy_in_done"}, busy, 0);
    repeat (2) @(negedge clk);
    chk({tag, " done_cnt"}, done_cnt, 1);
    chk({tag, " error"}, error, v.exp_err);
    chk({tag, " n_rd"}, rd_log.size(), v.exp_nrd);
    chk({tag, " n_wr"}, wr_log.size(), v.exp_nrd);
    if (v.len == 0) begin
      chk({tag, " no_activity"}, any_valid, 0);
      chk({tag, " no_busy"}, any_busy, 0);
    end
    n = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
    for (int i = 0; i < n; i++) chk({tag, " rd_burst"}, {rd_log[i].a, rd_log[i].b}, {exp_rd[i].a, exp_rd[i].b});
    n = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
    for (int i = 0; i < n; i++) chk({tag, " wr_burst"}, {wr_log[i].a, wr_log[i].b}, {exp_wr[i].a, exp_wr[i].b});
    chk({tag, " n_words"}, got.size(), exp_w.size());
    n = (got.size() < exp_w.size()) ? got.size() : exp_w.size();
    for (int i = 0; i < n; i++) chk({tag, " word"}, {got[i].a, got[i].b}, {exp_w[i].a, exp_w[i].b});
    prev_err = v.exp_err;
  endtask

  vec_t tbl[9];
  vec_t rv;
  int   cyc;

  initial begin
    tbl[0] = '{32'h100,      32'h200,      32'd5,  10, 0,  0, 99, 1, 1'b0};
    tbl[1] = '{32'h1000,     32'h2000,     32'd40, 2,  0,  0, 99, 3, 1'b0};
    tbl[2] = '{32'h300,      32'h400,      32'd0,  0,  0,  0, 99, 0, 1'b0};
    tbl[3] = '{32'h3000,     32'h3800,     32'd37, 3,  50, 1, 99, 3, 1'b0};
    tbl[4] = '{32'h6000,     32'h7000,     32'd32, 1,  0,  0, 1,  2, 1'b1};
    tbl[5] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'd20, 0,  20, 2, 99, 2, 1'b0};
    tbl[6] = '{32'h10,       32'h20,       32'd16, 0,  0,  0, 99, 1, 1'b0};
    tbl[7] = '{32'h40,       32'h80,       32'd17, 4,  30, 1, 99, 2, 1'b0};
    tbl[8] = '{32'h7,        32'h9,        32'd1,  0,  0,  1, 0,  1, 1'b1};

    rst_n = 0; start = 0; src_addr = 0; dst_addr = 0; len = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {busy, done, error, req_read_addr_valid, resp_read_data_ready,
                      req_write_addr_valid, req_write_data_valid, resp_write_status_ready}, 0);
    chk("reset_addr", {req_read_addr, req_write_addr}, 0);
    chk("reset_len", {req_read_len, req_write_len}, 0);
    rst_n = 1;

    for (int i = 0; i < 9; i++) run_copy(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 8; i++) begin
      rv.src = $urandom; rv.dst = $urandom; rv.len = 32'($urandom_range(50, 0));
      rv.lat = $urandom_range(6, 0); rv.gap = $urandom_range(50, 0); rv.wmode = $urandom_range(2, 0);
      rv.fail = ($urandom_range(2, 0) == 0) ? $urandom_range(3, 0) : 99;
      rv.exp_nrd = -1; rv.exp_err = 1'b0;
      run_copy(rv, $sformatf("rnd%0d", i));
    end

    // Abort in the middle of the write phase, then confirm a fresh copy still works.
    cfg_lat = 2; cfg_gap = 0; cfg_wmode = 1; cfg_fail = 99;
    clear_logs();
    @(negedge clk); start = 1; src_addr = 32'h4000; dst_addr = 32'h5000; len = 32'd20;
    @(negedge clk); start = 0;
    cyc = 0;
    while (!req_write_data_valid && cyc < 500) begin @(negedge clk); cyc++; end
    chk("rst_reach_wr_data", cyc < 500, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_async_ctl", {busy, done, error, req_read_addr_valid, resp_read_data_ready,
                          req_write_addr_valid, req_write_data_valid, resp_write_status_ready}, 0);
    chk("rst_async_addr", {req_read_addr, req_write_addr, req_write_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("rst_no_done", done_cnt, 0);
    prev_err = 1'b0;
    rv = '{32'h8000, 32'h9000, 32'd3, 1, 0, 0, 99, 1, 1'b0};
    run_copy(rv, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
